bsg_mesh_multicast_encoder: RTL and testbench
=============================================

# bsg_mesh_multicast_encoder

Source-side companion to the dimension-ordered routing decoder. It accepts one rectangular multicast request, with destination ranges in X and Y plus a payload. It serializes the request into a stream of unicast packets, one per tile in the rectangle, on a valid/ready link. Each packet's x_dirs/y_dirs fields are exactly what the downstream DOR decoder consumes. It sits between a tile's core-side network interface and the router's P input.

## Interface
- x_cord_width_p, -1 (must be set), width of X coordinate
- y_cord_width_p, -1 (must be set), width of Y coordinate
- data_width_p, -1 (must be set), payload width
- XY_order_p, 1, 1: X is the inner scan loop (row-major), 0: Y is the inner scan loop
- clk_i  input  1  clock
- reset_i  input  1  asynchronous, active-high reset
- v_i  input  1  request valid
- ready_o  output  1  request accepted when v_i & ready_o
- x_lo_i, x_hi_i  input  x_cord_width_p  inclusive X range
- y_lo_i, y_hi_i  input  y_cord_width_p  inclusive Y range
- data_i  input  data_width_p  payload replicated into every packet
- v_o  output  1  packet valid
- ready_i  input  1  downstream accepts when v_o & ready_i
- x_dirs_o  output  x_cord_width_p  destination X of current packet
- y_dirs_o  output  y_cord_width_p  destination Y of current packet
- data_o  output  data_width_p  latched payload
- last_o  output  1  current packet is the final one of the request
- error_o  output  1  one-cycle pulse, malformed request dropped

## Operation
- States: IDLE, CHECK, SEND.
- IDLE:
  - ready_o=1.
  - On handshake, latch x_lo, x_hi, y_lo, y_hi and data.
  - Set cx=x_lo, cy=y_lo and go to CHECK.
- CHECK (1 cycle):
  - If x_lo>x_hi or y_lo>y_hi (unsigned), pulse error_o and return to IDLE. No packet is emitted.
  - Otherwise go to SEND.
- SEND:
  - v_o=1, x_dirs_o=cx, y_dirs_o=cy.
  - last_o=(cx==x_hi)&(cy==y_hi).
  - Outputs are held stable while ready_i=0.
- On v_o&ready_i:
  - If last_o, go to IDLE.
  - Else if XY_order_p=1: when cx==x_hi, set cx=x_lo and cy=cy+1; otherwise cx=cx+1.
  - Else (XY_order_p=0): the symmetric rule with Y as the inner loop.
- Termination uses equality compares only. An all-ones x_hi/y_hi never wraps the counter, and there is no width growth.
- Total packets emitted = (x_hi-x_lo+1)*(y_hi-y_lo+1). There is no internal count register.
- ready_o=0 in CHECK and SEND. Only one request is in flight.
- Reset (asynchronous):
  - State goes to IDLE.
  - v_o=0, last_o=0, error_o=0.
  - ready_o=0 while reset_i is high, 1 on the first cycle after.
  - Coordinate and data registers are don't-care.
  - Reset mid-SEND abandons the remaining packets with no error.

## Timing
- A request accepted at edge N gives CHECK in cycle N+1, and either the first v_o or error_o in cycle N+2.
- Steady-state throughput: 1 packet/cycle with ready_i held high.
- After the last handshake, ready_o=1 in the next cycle. The minimum request-to-request gap is 3 cycles for a 1-tile rectangle.
- All outputs come directly from registers. There is no combinational path from v_i/ready_i to v_o/ready_o.

## Structure
- State enum typedef bsg_mesh_mc_state_e {eIDLE, eCHECK, eSEND} goes in bsg_mesh_router_pkg alongside the direction constants.
- One natural sub-module: bsg_mesh_cord_scan, a 2D inclusive-range counter.
  - Inputs: lo/hi per dimension, load_i, yumi_i, XY_order_p.
  - Outputs: cx, cy, last.
- The top level holds the FSM, the payload register and the handshakes.

## Test plan
- Single tile: x=[2,2], y=[3,3], ready_i=1 -> exactly one packet (2,3) with last_o=1, v_o in cycle N+2, ready_o back 1 the cycle after.
- Rectangle x=[1,2], y=[0,1], XY_order_p=1 -> packets (1,0),(2,0),(1,1),(2,1); last_o only on (2,1); payload identical on all four.
- Same rectangle with XY_order_p=0 -> packets (1,0),(1,1),(2,0),(2,1).
- Backpressure: ready_i toggled randomly during a 3x3 request -> 9 packets, no duplicates or skips, outputs stable while stalled.
- Malformed request x_lo=5, x_hi=4 -> error_o pulses exactly once at N+2, v_o never asserts, ready_o=1 at N+3.
- Edge and reset cases:
  - Full-range x=[0,max], y=[max,max] -> 2^x_cord_width_p packets, no wrap.
  - reset_i asserted asynchronously mid-SEND -> v_o falls without a clock edge, FSM in IDLE after release.

Source files
------------

// File: rtl/bsg_mesh_router_pkg.sv
// Shared definitions for the mesh router slice: port direction encodings
// and the state type of the multicast encoder FSM.
package bsg_mesh_router_pkg;

  // Router port direction encodings consumed by the DOR decoder.
  localparam logic [2:0] dir_p_lp = 3'd0;
  localparam logic [2:0] dir_w_lp = 3'd1;
  localparam logic [2:0] dir_e_lp = 3'd2;
  localparam logic [2:0] dir_n_lp = 3'd3;
  localparam logic [2:0] dir_s_lp = 3'd4;

  // Multicast encoder FSM states.
  typedef enum logic [1:0] {
    eIDLE  = 2'd0,
    eCHECK = 2'd1,
    eSEND  = 2'd2
  } bsg_mesh_mc_state_e;

endpackage

// File: rtl/bsg_mesh_cord_scan.sv
// Two-dimensional inclusive-range coordinate counter. Loads a rectangle and
// walks it one tile per yumi, either X-inner (row-major) or Y-inner.
// Termination is by equality against the high bound, so an all-ones bound
// never wraps and no extra width is needed.
module bsg_mesh_cord_scan #(
  parameter int x_cord_width_p = -1,
  parameter int y_cord_width_p = -1,
  parameter int XY_order_p     = 1
) (
  input  logic                      clk_i,
  input  logic                      load_i,
  input  logic                      yumi_i,
  input  logic [x_cord_width_p-1:0] x_lo_i,
  input  logic [x_cord_width_p-1:0] x_hi_i,
  input  logic [y_cord_width_p-1:0] y_lo_i,
  input  logic [y_cord_width_p-1:0] y_hi_i,
  output logic [x_cord_width_p-1:0] cx_o,
  output logic [y_cord_width_p-1:0] cy_o,
  output logic                      last_o
);

  logic [x_cord_width_p-1:0] cx_r, x_lo_r, x_hi_r;
  logic [y_cord_width_p-1:0] cy_r, y_lo_r, y_hi_r;
  logic                      x_at_hi, y_at_hi;

  assign x_at_hi = (cx_r == x_hi_r);
  assign y_at_hi = (cy_r == y_hi_r);
  assign last_o  = x_at_hi & y_at_hi;
  assign cx_o    = cx_r;
  assign cy_o    = cy_r;

  // Load the rectangle, then step the inner dimension and carry into the outer.
  // NOTE: datapath registers carry no reset; they are always loaded before use.
  always_ff @(posedge clk_i) begin
    if (load_i) begin
      x_lo_r <= x_lo_i;
      x_hi_r <= x_hi_i;
      y_lo_r <= y_lo_i;
      y_hi_r <= y_hi_i;
      cx_r   <= x_lo_i;
      cy_r   <= y_lo_i;
    end else if (yumi_i && !last_o) begin
      if (XY_order_p != 0) begin
        if (x_at_hi) begin
          cx_r <= x_lo_r;
          cy_r <= cy_r + 1'b1;
        end else begin
          cx_r <= cx_r + 1'b1;
        end
      end else begin
        if (y_at_hi) begin
          cy_r <= y_lo_r;
          cx_r <= cx_r + 1'b1;
        end else begin
          cy_r <= cy_r + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/bsg_mesh_multicast_encoder.sv
// Serializes one rectangular multicast request into a stream of unicast
// packets, one per tile, on a valid/ready link. All handshake outputs are
// registered; there is no combinational path from v_i/ready_i to v_o/ready_o.
module bsg_mesh_multicast_encoder
  import bsg_mesh_router_pkg::*;
#(
  parameter int x_cord_width_p = -1,
  parameter int y_cord_width_p = -1,
  parameter int data_width_p   = -1,
  parameter int XY_order_p     = 1
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      v_i,
  output logic                      ready_o,
  input  logic [x_cord_width_p-1:0] x_lo_i,
  input  logic [x_cord_width_p-1:0] x_hi_i,
  input  logic [y_cord_width_p-1:0] y_lo_i,
  input  logic [y_cord_width_p-1:0] y_hi_i,
  input  logic [data_width_p-1:0]   data_i,
  output logic                      v_o,
  input  logic                      ready_i,
  output logic [x_cord_width_p-1:0] x_dirs_o,
  output logic [y_cord_width_p-1:0] y_dirs_o,
  output logic [data_width_p-1:0]   data_o,
  output logic                      last_o,
  output logic                      error_o
);

  bsg_mesh_mc_state_e        state_r, state_n;
  logic                      v_r, ready_r, error_r, error_n;
  logic                      bad_r;
  logic [data_width_p-1:0]   data_r;
  logic                      req_accept, pkt_yumi, scan_last;

  assign req_accept = v_i & ready_r;
  assign pkt_yumi   = v_r & ready_i;

  bsg_mesh_cord_scan #(
    .x_cord_width_p(x_cord_width_p),
    .y_cord_width_p(y_cord_width_p),
    .XY_order_p    (XY_order_p)
  ) scan (
    .clk_i (clk_i),
    .load_i(req_accept),
    .yumi_i(pkt_yumi),
    .x_lo_i(x_lo_i),
    .x_hi_i(x_hi_i),
    .y_lo_i(y_lo_i),
    .y_hi_i(y_hi_i),
    .cx_o  (x_dirs_o),
    .cy_o  (y_dirs_o),
    .last_o(scan_last)
  );

  // Next-state logic: accept, validate the latched range, then stream packets.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_n = state_r;
    error_n = 1'b0;
    case (state_r)
      eIDLE:  if (req_accept) state_n = eCHECK;
      eCHECK: begin
        error_n = bad_r;
        state_n = bad_r ? eIDLE : eSEND;
      end
      eSEND:  if (pkt_yumi && scan_last) state_n = eIDLE;
      default: state_n = eIDLE;
    endcase
  end

  // Control registers; ready stays low during the error pulse so the next
  // request is taken no earlier than the cycle after it.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r <= eIDLE;
      v_r     <= 1'b0;
      ready_r <= 1'b0;
      error_r <= 1'b0;
    end else begin
      state_r <= state_n;
      v_r     <= (state_n == eSEND);
      ready_r <= (state_n == eIDLE) && !error_n;
      error_r <= error_n;
    end
  end

  // Payload and range-validity flag captured on request acceptance.
  always_ff @(posedge clk_i) begin
    if (req_accept) begin
      data_r <= data_i;
      bad_r  <= (x_lo_i > x_hi_i) || (y_lo_i > y_hi_i);
    end
  end

  assign ready_o = ready_r;
  assign v_o     = v_r;
  assign error_o = error_r;
  assign data_o  = data_r;
  assign last_o  = v_r & scan_last;

endmodule

// File: tb/tb_bsg_mesh_multicast_encoder.sv
// Directed bench: two encoder instances (X-inner and Y-inner) share one
// stimulus stream; each packet is compared against a scan-order model.
module tb_bsg_mesh_multicast_encoder;

  localparam int XW = 3;
  localparam int YW = 3;
  localparam int DW = 16;

  logic          clk, reset_i, v_i, ready_i;
  logic [XW-1:0] x_lo_i, x_hi_i;
  logic [YW-1:0] y_lo_i, y_hi_i;
  logic [DW-1:0] data_i;

  logic          ready_o0, v_o0, last_o0, error_o0;
  logic [XW-1:0] x_o0;
  logic [YW-1:0] y_o0;
  logic [DW-1:0] data_o0;
  logic          ready_o1, v_o1, last_o1, error_o1;
  logic [XW-1:0] x_o1;
  logic [YW-1:0] y_o1;
  logic [DW-1:0] data_o1;

  int total = 0;
  int bad   = 0;

  bsg_mesh_multicast_encoder #(
    .x_cord_width_p(XW), .y_cord_width_p(YW), .data_width_p(DW), .XY_order_p(1)
  ) dut_xy (
    .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .ready_o(ready_o0),
    .x_lo_i(x_lo_i), .x_hi_i(x_hi_i), .y_lo_i(y_lo_i), .y_hi_i(y_hi_i),
    .data_i(data_i), .v_o(v_o0), .ready_i(ready_i), .x_dirs_o(x_o0),
    .y_dirs_o(y_o0), .data_o(data_o0), .last_o(last_o0), .error_o(error_o0)
  );

  bsg_mesh_multicast_encoder #(
    .x_cord_width_p(XW), .y_cord_width_p(YW), .data_width_p(DW), .XY_order_p(0)
  ) dut_yx (
    .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .ready_o(ready_o1),
    .x_lo_i(x_lo_i), .x_hi_i(x_hi_i), .y_lo_i(y_lo_i), .y_hi_i(y_hi_i),
    .data_i(data_i), .v_o(v_o1), .ready_i(ready_i), .x_dirs_o(x_o1),
    .y_dirs_o(y_o1), .data_o(data_o1), .last_o(last_o1), .error_o(error_o1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request and follow it to completion. Expected packet order is
  // built independently for both scan orders from plain integer loops.
  task automatic run_req(input int xlo, input int xhi, input int ylo, input int yhi,
                         input logic [DW-1:0] d, input bit bp, input bit expect_err);
    logic [5:0] exp0[$];
    logic [5:0] exp1[$];
    logic [5:0] e0, e1;
    int n, idx, cyc, guard;
    if (!expect_err) begin
      for (int y = ylo; y <= yhi; y++)
        for (int x = xlo; x <= xhi; x++) exp0.push_back({3'(x), 3'(y)});
      for (int x = xlo; x <= xhi; x++)
        for (int y = ylo; y <= yhi; y++) exp1.push_back({3'(x), 3'(y)});
    end
    n = exp0.size();

    guard = 0;
    while (!(ready_o0 && ready_o1) && guard < 20) begin
      tick();
      guard++;
    end
    check("ready_wait", {31'b0, ready_o0 & ready_o1}, 32'd1);

    v_i = 1'b1; x_lo_i = 3'(xlo); x_hi_i = 3'(xhi);
    y_lo_i = 3'(ylo); y_hi_i = 3'(yhi); data_i = d; ready_i = 1'b1;
    tick();                       // accepted at this edge
    v_i = 1'b0;
    check("check_ready", {31'b0, ready_o0}, 32'd0);
    check("check_v",     {31'b0, v_o0 | v_o1}, 32'd0);
    check("check_err",   {31'b0, error_o0 | error_o1}, 32'd0);
    tick();                       // first output cycle

    if (expect_err) begin
      check("err_pulse0",  {31'b0, error_o0}, 32'd1);
      check("err_pulse1",  {31'b0, error_o1}, 32'd1);
      check("err_v",       {31'b0, v_o0 | v_o1}, 32'd0);
      check("err_ready",   {31'b0, ready_o0}, 32'd0);
      tick();
      check("err_once",    {31'b0, error_o0 | error_o1}, 32'd0);
      check("err_ready1",  {31'b0, ready_o0 & ready_o1}, 32'd1);
      check("err_v1",      {31'b0, v_o0 | v_o1}, 32'd0);
      return;
    end

    idx = 0;
    cyc = 0;
    while (idx < n && cyc < 300) begin
      e0 = exp0[idx];
      e1 = exp1[idx];
      check("v_xy",    {31'b0, v_o0}, 32'd1);
      check("v_yx",    {31'b0, v_o1}, 32'd1);
      check("x_xy",    {29'b0, x_o0}, {29'b0, e0[5:3]});
      check("y_xy",    {29'b0, y_o0}, {29'b0, e0[2:0]});
      check("x_yx",    {29'b0, x_o1}, {29'b0, e1[5:3]});
      check("y_yx",    {29'b0, y_o1}, {29'b0, e1[2:0]});
      check("last_xy", {31'b0, last_o0}, {31'b0, idx == n - 1});
      check("last_yx", {31'b0, last_o1}, {31'b0, idx == n - 1});
      check("data_xy", {16'b0, data_o0}, {16'b0, d});
      check("data_yx", {16'b0, data_o1}, {16'b0, d});
      check("busy",    {31'b0, ready_o0 | ready_o1}, 32'd0);
      ready_i = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      if (ready_i) idx++;
      cyc++;
    end
    check("pkt_count", idx, n);
    ready_i = 1'b1;
    check("done_ready", {31'b0, ready_o0 & ready_o1}, 32'd1);
    check("done_v",     {31'b0, v_o0 | v_o1}, 32'd0);
    check("done_last",  {31'b0, last_o0 | last_o1}, 32'd0);
  endtask

  initial begin
    reset_i = 1'b1; v_i = 1'b0; ready_i = 1'b1;
    x_lo_i = '0; x_hi_i = '0; y_lo_i = '0; y_hi_i = '0; data_i = '0;
    tick();
    tick();
    check("rst_ready", {31'b0, ready_o0 | ready_o1}, 32'd0);
    check("rst_v",     {31'b0, v_o0 | v_o1}, 32'd0);
    check("rst_err",   {31'b0, error_o0 | error_o1}, 32'd0);
    check("rst_last",  {31'b0, last_o0 | last_o1}, 32'd0);
    reset_i = 1'b0;
    tick();
    check("post_rst_ready", {31'b0, ready_o0 & ready_o1}, 32'd1);

    run_req(2, 2, 3, 3, 16'hA5A5, 1'b0, 1'b0);   // single tile
    run_req(1, 2, 0, 1, 16'h1234, 1'b0, 1'b0);   // 2x2, both orders
    run_req(0, 2, 4, 6, 16'hBEEF, 1'b1, 1'b0);   // 3x3 with backpressure
    run_req(5, 4, 0, 0, 16'hDEAD, 1'b0, 1'b1);   // malformed X range
    run_req(0, 1, 3, 2, 16'hDEAD, 1'b0, 1'b1);   // malformed Y range
    run_req(0, 7, 7, 7, 16'h0F0F, 1'b0, 1'b0);   // full X range, Y at max

    // Asynchronous reset in the middle of a stream.
    v_i = 1'b1; x_lo_i = 3'd0; x_hi_i = 3'd2; y_lo_i = 3'd0; y_hi_i = 3'd2;
    data_i = 16'h5555; ready_i = 1'b1;
    tick();
    v_i = 1'b0;
    tick();
    tick();
    check("mid_v_before", {31'b0, v_o0 & v_o1}, 32'd1);
    #3 reset_i = 1'b1;
    #1;
    check("async_v",     {31'b0, v_o0 | v_o1}, 32'd0);
    check("async_ready", {31'b0, ready_o0 | ready_o1}, 32'd0);
    check("async_last",  {31'b0, last_o0 | last_o1}, 32'd0);
    tick();
    reset_i = 1'b0;
    tick();
    check("rel_ready", {31'b0, ready_o0 & ready_o1}, 32'd1);
    check("rel_v",     {31'b0, v_o0 | v_o1}, 32'd0);
    check("rel_err",   {31'b0, error_o0 | error_o1}, 32'd0);
    run_req(7, 7, 0, 0, 16'hC3C3, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
